genius_seq_ctrl: RTL

Game-sequence controller for the Genius (Simon) datapath. It samples the pseudo-random generator once per round and appends a 2-bit colour to an internal sequence memory. It then plays the whole sequence on the four LEDs, collects and checks the player's button presses, and flags win, loss or timeout. It sits between the random generator, the LED/button I/O and the top-level game FSM.

---
 rtl/genius_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/genius_seq_ctrl.sv
// Genius (Simon) sequence controller: grows a random colour sequence one entry
// per round, plays it on the LEDs, then checks the player's presses against it.
module genius_seq_ctrl #(
  parameter  int DATA_WIDTH     = 8,
  parameter  int MAX_LEN        = 16,
  parameter  int SHOW_CYCLES    = 4,
  parameter  int GAP_CYCLES     = 2,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int LW             = $clog2(MAX_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rnd,
  input  logic [3:0]            btn,
  input  logic                  btn_valid,
  output logic                  rnd_req,
  output logic [3:0]            led,
  output logic                  input_en,
  output logic [LW-1:0]         level,
  output logic                  busy,
  output logic                  win,
  output logic                  lose
);

  localparam int IW   = $clog2(MAX_LEN);
  localparam int CMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHOW_ON, S_SHOW_OFF, S_WAIT_IN, S_WIN, S_LOSE
  } state_e;

  state_e        state_q;
  logic [LW-1:0] level_q;
  logic [IW-1:0] idx_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]    led_q;
  logic          rnd_req_q;
  logic          input_en_q;
  logic          busy_q;
  logic          win_q;
  logic          lose_q;
  logic [1:0]    seq_q [MAX_LEN];

  logic          idx_last;
  logic [1:0]    first_col;
  logic          unused_rnd;

  function automatic logic [3:0] onehot(input logic [1:0] col);
    return 4'b0001 << col;
  endfunction

  assign idx_last   = (LW'(idx_q) == level_q - LW'(1));
  // In round one seq[0] is written on the same edge that starts playback.
  assign first_col  = (level_q == '0) ? rnd[1:0] : seq_q[0];
  assign unused_rnd = ^rnd[DATA_WIDTH-1:2];

  // NOTE: the sequence store has no reset; every entry is written in ADD
  // before playback or press checking can ever read it.
  always_ff @(posedge clk) begin
    if (state_q == S_ADD && level_q < LW'(MAX_LEN)) begin
      seq_q[level_q[IW-1:0]] <= rnd[1:0];
    end
  end

  // NOTE: non-blocking assignments everywhere in sequential logic, so each
  // branch below reads the pre-edge register values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      level_q    <= '0;
      idx_q      <= '0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      led_q      <= '0;
      rnd_req_q  <= 1'b0;
      input_en_q <= 1'b0;
      busy_q     <= 1'b0;
      win_q      <= 1'b0;
      lose_q     <= 1'b0;
    end else begin
      rnd_req_q <= 1'b0;
      case (state_q)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) begin
            state_q   <= S_ADD;
            level_q   <= '0;
            rnd_req_q <= 1'b1;
            busy_q    <= 1'b1;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
          end
        end
        S_ADD: begin
          if (level_q < LW'(MAX_LEN)) level_q <= level_q + LW'(1);
          idx_q   <= '0;
          cnt_q   <= '0;
          led_q   <= onehot(first_col);
          state_q <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (cnt_q == CW'(SHOW_CYCLES - 1)) begin
            cnt_q   <= '0;
            led_q   <= '0;
            state_q <= S_SHOW_OFF;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_SHOW_OFF: begin
          if (cnt_q == CW'(GAP_CYCLES - 1)) begin
            cnt_q <= '0;
            if (idx_last) begin
              idx_q      <= '0;
              tmo_q      <= '0;
              input_en_q <= 1'b1;
              state_q    <= S_WAIT_IN;
            end else begin
              idx_q   <= idx_q + IW'(1);
              led_q   <= onehot(seq_q[idx_q + IW'(1)]);
              state_q <= S_SHOW_ON;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_WAIT_IN: begin
          // A press on the final timeout cycle wins over the timeout.
          if (btn_valid) begin
            if (btn != onehot(seq_q[idx_q])) begin
              input_en_q <= 1'b0;
              busy_q     <= 1'b0;
              lose_q     <= 1'b1;
              state_q    <= S_LOSE;
            end else if (!idx_last) begin
              idx_q <= idx_q + IW'(1);
              tmo_q <= '0;
            end else if (level_q == LW'(MAX_LEN)) begin
              input_en_q <= 1'b0;
              busy_q     <= 1'b0;
              win_q      <= 1'b1;
              state_q    <= S_WIN;
            end else begin
              input_en_q <= 1'b0;
              rnd_req_q  <= 1'b1;
              state_q    <= S_ADD;
            end
          end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
            input_en_q <= 1'b0;
            busy_q     <= 1'b0;
            lose_q     <= 1'b1;
            state_q    <= S_LOSE;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rnd_req  = rnd_req_q;
  assign led      = led_q;
  assign input_en = input_en_q;
  assign level    = level_q;
  assign busy     = busy_q;
  assign win      = win_q;
  assign lose     = lose_q;

endmodule
